// File: rtl/cache_line_controller.sv
// cache_line_controller
//
// Multi-word-line cache controller FSM. Sits between the processor memory
// stage and the cache/RAM datapath. It sequences the following steps:
// clear, tag lookup, dirty-line writeback, line fill and the final cache
// access. Indirect accesses (hops) and write-allocate are supported.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmdValid/cmdReady   command handshake; cmdOp 00 clear, 01 nop,
//                       10 read, 11 write; cmdHops = extra indirect accesses
//   isHit, isClean      tag compare results, sampled in CHECK
//   ramReady            RAM finished the current beat
//   ramReadEnable,
//   ramWriteEnable      RAM beat request (FILL / WB)
//   ramBeat             word index of the current beat
//   cacheIn             00 clear, 01 lookup, 10 hold, 11 write word
//   dataInSel           cache write source: 0 CPU, 1 RAM
//   outputReady         cache access completing this cycle
//   done                one-cycle pulse when a command finishes
//   error               one-cycle pulse after a RAM beat timeout
//   busy                FSM not in IDLE
//   state               encoded current state (debug)
module cache_line_controller #(
  parameter int LINE_WORDS     = 4,
  parameter int BEAT_W         = $clog2(LINE_WORDS),
  parameter int IND_W          = 2,
  parameter int WRITE_ALLOCATE = 1,
  parameter int TIMEOUT        = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmdValid,
  input  logic [1:0]        cmdOp,
  input  logic [IND_W-1:0]  cmdHops,
  output logic              cmdReady,
  input  logic              isHit,
  input  logic              isClean,
  input  logic              ramReady,
  output logic              ramReadEnable,
  output logic              ramWriteEnable,
  output logic [BEAT_W-1:0] ramBeat,
  output logic [1:0]        cacheIn,
  output logic              dataInSel,
  output logic              outputReady,
  output logic              done,
  output logic              error,
  output logic              busy,
  output logic [3:0]        state
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CLEAR  = 4'd1,
    S_LOOKUP = 4'd2,
    S_CHECK  = 4'd3,
    S_WB     = 4'd4,
    S_FILL   = 4'd5,
    S_ACCESS = 4'd6
  } state_t;

  state_t             state_reg;
  logic [1:0]         op_reg;
  logic [IND_W-1:0]   hops_reg;
  logic [BEAT_W-1:0]  beat_reg;
  logic [TMO_W-1:0]   tmo_reg;
  logic               nop_done_reg;
  logic               error_reg;

  logic is_write;
  logic fill_after_miss;

  assign is_write = (op_reg == 2'b11);
  // A read miss always fills; a write miss fills only in write-allocate mode.
  assign fill_after_miss = !is_write || (WRITE_ALLOCATE != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      op_reg       <= 2'b01;
      hops_reg     <= '0;
      beat_reg     <= '0;
      tmo_reg      <= '0;
      nop_done_reg <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      nop_done_reg <= 1'b0;
      error_reg    <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (cmdValid) begin
            op_reg   <= cmdOp;
            hops_reg <= cmdHops;
            case (cmdOp)
              2'b00:   state_reg <= S_CLEAR;
              2'b01:   nop_done_reg <= 1'b1;
              default: state_reg <= S_LOOKUP;
            endcase
          end
        end
        S_CLEAR:  state_reg <= S_IDLE;
        S_LOOKUP: state_reg <= S_CHECK;
        S_CHECK: begin
          beat_reg <= '0;
          tmo_reg  <= '0;
          if (isHit)                state_reg <= S_ACCESS;
          else if (!isClean)        state_reg <= S_WB;
          else if (fill_after_miss) state_reg <= S_FILL;
          else                      state_reg <= S_ACCESS;
        end
        S_WB, S_FILL: begin
          if (ramReady) begin
            // Clearing here also covers the WB -> FILL entry.
            tmo_reg <= '0;
            if (beat_reg == LAST_BEAT) begin
              beat_reg <= '0;
              if (state_reg == S_WB && fill_after_miss) state_reg <= S_FILL;
              else                                      state_reg <= S_ACCESS;
            end else begin
              beat_reg <= beat_reg + BEAT_W'(1);
            end
          end else if (tmo_reg == TMO_LAST) begin
            // Give up on the command: the pulse appears in the first IDLE cycle.
            error_reg <= 1'b1;
            state_reg <= S_IDLE;
            beat_reg  <= '0;
            hops_reg  <= '0;
            tmo_reg   <= '0;
          end else begin
            tmo_reg <= tmo_reg + TMO_W'(1);
          end
        end
        S_ACCESS: begin
          if (hops_reg != '0) begin
            hops_reg  <= hops_reg - IND_W'(1);
            state_reg <= S_LOOKUP;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the registered state. The only exception is the
  // fill write strobe, which must coincide with the beat's ramReady.
  always_comb begin
    cmdReady       = 1'b0;
    ramReadEnable  = 1'b0;
    ramWriteEnable = 1'b0;
    cacheIn        = 2'b10;
    dataInSel      = 1'b0;
    outputReady    = 1'b0;
    done           = nop_done_reg;
    case (state_reg)
      S_IDLE:   cmdReady = 1'b1;
      S_CLEAR: begin
        cacheIn = 2'b00;
        done    = 1'b1;
      end
      S_LOOKUP: cacheIn = 2'b01;
      S_WB:     ramWriteEnable = 1'b1;
      S_FILL: begin
        ramReadEnable = 1'b1;
        if (ramReady) begin
          cacheIn   = 2'b11;
          dataInSel = 1'b1;
        end
      end
      S_ACCESS: begin
        outputReady = 1'b1;
        if (is_write) cacheIn = 2'b11;
        if (hops_reg == '0) done = 1'b1;
      end
      default: ;
    endcase
  end

  // The beat counter is held at zero outside WB/FILL.
  assign ramBeat = beat_reg;
  assign error   = error_reg;
  assign busy    = (state_reg != S_IDLE);
  assign state   = state_reg;

endmodule

// File: tb/tb_cache_line_controller.sv
module tb_cache_line_controller;

  localparam int LW  = 4;
  localparam int TMO = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [1:0] cmd_hops;
  logic       is_hit, is_clean, ram_ready;
  int         sel;   // 0: write-allocate instance, 1: write-around instance

  logic va, vb;
  assign va = cmd_valid && (sel == 0);
  assign vb = cmd_valid && (sel == 1);

  logic       a_cmd_ready, a_ren, a_wen, a_dsel, a_ordy, a_done, a_err, a_busy;
  logic [1:0] a_beat, a_cache_in;
  logic [3:0] a_state;
  logic       b_cmd_ready, b_ren, b_wen, b_dsel, b_ordy, b_done, b_err, b_busy;
  logic [1:0] b_beat, b_cache_in;
  logic [3:0] b_state;

  cache_line_controller #(.LINE_WORDS(LW), .IND_W(2), .WRITE_ALLOCATE(1), .TIMEOUT(TMO)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmdValid(va), .cmdOp(cmd_op), .cmdHops(cmd_hops),
    .cmdReady(a_cmd_ready), .isHit(is_hit), .isClean(is_clean), .ramReady(ram_ready),
    .ramReadEnable(a_ren), .ramWriteEnable(a_wen), .ramBeat(a_beat), .cacheIn(a_cache_in),
    .dataInSel(a_dsel), .outputReady(a_ordy), .done(a_done), .error(a_err),
    .busy(a_busy), .state(a_state));

  cache_line_controller #(.LINE_WORDS(LW), .IND_W(2), .WRITE_ALLOCATE(0), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmdValid(vb), .cmdOp(cmd_op), .cmdHops(cmd_hops),
    .cmdReady(b_cmd_ready), .isHit(is_hit), .isClean(is_clean), .ramReady(ram_ready),
    .ramReadEnable(b_ren), .ramWriteEnable(b_wen), .ramBeat(b_beat), .cacheIn(b_cache_in),
    .dataInSel(b_dsel), .outputReady(b_ordy), .done(b_done), .error(b_err),
    .busy(b_busy), .state(b_state));

  // Observed instance
  logic       m_cmd_ready, m_ren, m_wen, m_dsel, m_ordy, m_done, m_err, m_busy;
  logic [1:0] m_beat, m_cache_in;
  logic [3:0] m_state;
  always_comb begin
    if (sel == 0) begin
      m_cmd_ready = a_cmd_ready; m_ren = a_ren; m_wen = a_wen; m_dsel = a_dsel;
      m_ordy = a_ordy; m_done = a_done; m_err = a_err; m_busy = a_busy;
      m_beat = a_beat; m_cache_in = a_cache_in; m_state = a_state;
    end else begin
      m_cmd_ready = b_cmd_ready; m_ren = b_ren; m_wen = b_wen; m_dsel = b_dsel;
      m_ordy = b_ordy; m_done = b_done; m_err = b_err; m_busy = b_busy;
      m_beat = b_beat; m_cache_in = b_cache_in; m_state = b_state;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Per-lookup tag results; index advances after each cache access.
  bit lk_hit[4];
  bit lk_clean[4];
  int lk_idx;

  // Event codes: 256+b WB beat, 512+b FILL beat, 768+2*cacheIn+dsel access,
  // 1024 clear strobe, 1280 lookup strobe.
  int obs_q[$];
  int exp_q[$];

  // Reference: expected event list and done latency, from the command rules.
  task automatic model(input bit wa, input int op, input int hops, input int stall,
                       output int lat);
    exp_q.delete();
    lat = 1;
    if (op == 0) begin
      exp_q.push_back(1024);
    end else if (op >= 2) begin
      lat = 0;
      for (int k = 0; k <= hops; k++) begin
        bit miss;
        miss = !lk_hit[k];
        exp_q.push_back(1280);
        lat += 2;
        if (miss && !lk_clean[k]) begin
          for (int b = 0; b < LW; b++) exp_q.push_back(256 + b);
          lat += LW * (stall + 1);
        end
        if (miss && (op == 2 || wa)) begin
          for (int b = 0; b < LW; b++) exp_q.push_back(512 + b);
          lat += LW * (stall + 1);
        end
        exp_q.push_back(op == 3 ? 768 + 6 : 768 + 4);
        lat += 1;
      end
    end
  endtask

  task automatic compare_events(input string name);
    int bad;
    bad = -1;
    check({name, "_evt_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (obs_q[i] != exp_q[i]) begin
        bad = i;
        break;
      end
    end
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s_evt_order: event %0d got %0d expected %0d", name, bad,
               obs_q[bad], exp_q[bad]);
    end
  endtask

  // Issues one command and drives a RAM that answers after `stall` wait
  // cycles per beat. ended: 0 budget expired, 1 done, 2 error.
  task automatic run_cmd(input int s, input int op, input int hops, input int stall,
                         output int lat, output int ended, output int nwb,
                         output int nfill, output int nacc);
    int stall_left;
    sel = s; obs_q.delete(); lk_idx = 0;
    nwb = 0; nfill = 0; nacc = 0; lat = 0; ended = 0; stall_left = stall;
    @(negedge clk);
    cmd_op = 2'(op); cmd_hops = 2'(hops); cmd_valid = 1'b1; ram_ready = 1'b0;
    is_hit = lk_hit[0]; is_clean = lk_clean[0];
    #1 check("cmdReady_idle", int'(m_cmd_ready), 1);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      ram_ready = 1'b0;
      if (m_ren || m_wen) begin
        if (stall_left > 0) stall_left--;
        else begin
          ram_ready  = 1'b1;
          stall_left = stall;
        end
      end
      is_hit = lk_hit[lk_idx]; is_clean = lk_clean[lk_idx];
      #1;
      if (c == 1 && op != 1) check("cmdReady_fall", int'(m_cmd_ready), 0);
      if (m_wen && ram_ready) begin
        obs_q.push_back(256 + int'(m_beat)); nwb++;
      end
      if (m_ren && ram_ready) begin
        obs_q.push_back(512 + int'(m_beat)); nfill++;
        check("fill_cacheIn", int'(m_cache_in), 3);
        check("fill_dataInSel", int'(m_dsel), 1);
      end
      if (m_cache_in == 2'b00) obs_q.push_back(1024);
      if (m_cache_in == 2'b01) obs_q.push_back(1280);
      if (m_ordy) begin
        obs_q.push_back(768 + 2 * int'(m_cache_in) + int'(m_dsel));
        nacc++;
        if (lk_idx < 3) lk_idx++;
      end
      if (m_err) begin
        ended = 2; lat = c;
        check("no_done_with_error", int'(m_done), 0);
        break;
      end
      if (m_done) begin
        ended = 1; lat = c;
        break;
      end
    end
  endtask

  typedef struct {
    int s; int op; int hops; bit hit; bit clean; int stall;
    int lat; int nwb; int nfill; int nacc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, ended, nwb, nfill, nacc, mlat, found, stall_left;

    // s, op, hops, hit, clean, stall, lat, nwb, nfill, nacc
    vecs[0] = '{0, 2, 0, 1'b1, 1'b1, 0,  3, 0, 0, 1}; // read hit
    vecs[1] = '{0, 2, 0, 1'b0, 1'b0, 2, 27, 4, 4, 1}; // read miss dirty, 2-cycle stalls
    vecs[2] = '{0, 3, 0, 1'b0, 1'b1, 0,  7, 0, 4, 1}; // write miss clean, allocate
    vecs[3] = '{1, 3, 0, 1'b0, 1'b1, 0,  3, 0, 0, 1}; // write miss clean, write-around
    vecs[4] = '{0, 2, 2, 1'b1, 1'b1, 0,  9, 0, 0, 3}; // read, 2 hops, all hits
    vecs[5] = '{0, 0, 0, 1'b1, 1'b1, 0,  1, 0, 0, 0}; // clear
    vecs[6] = '{1, 1, 0, 1'b1, 1'b1, 0,  1, 0, 0, 0}; // nop
    vecs[7] = '{1, 3, 0, 1'b0, 1'b0, 1, 11, 4, 0, 1}; // write miss dirty, write-around
    vecs[8] = '{1, 2, 0, 1'b0, 1'b1, 0,  7, 0, 4, 1}; // read miss clean
    vecs[9] = '{1, 3, 1, 1'b1, 1'b1, 0,  6, 0, 0, 2}; // write hit, 1 hop

    sel = 0; cmd_valid = 1'b0; cmd_op = 2'b01; cmd_hops = 2'b00;
    is_hit = 1'b0; is_clean = 1'b0; ram_ready = 1'b0;
    rst_n = 1'b0;

    // Reset state
    #2;
    check("rst_state", int'(m_state), 0);
    check("rst_cmdReady", int'(m_cmd_ready), 1);
    check("rst_cacheIn", int'(m_cache_in), 2);
    check("rst_busy", int'(m_busy), 0);
    check("rst_enables", int'(m_ren) + int'(m_wen), 0);
    check("rst_done_err_ordy", int'(m_done) + int'(m_err) + int'(m_ordy), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 4; k++) begin
        lk_hit[k] = vecs[i].hit; lk_clean[k] = vecs[i].clean;
      end
      model(vecs[i].s == 0, vecs[i].op, vecs[i].hops, vecs[i].stall, mlat);
      run_cmd(vecs[i].s, vecs[i].op, vecs[i].hops, vecs[i].stall, lat, ended, nwb, nfill, nacc);
      $display("vec %0d: sel=%0d op=%0d hops=%0d lat=%0d wb=%0d fill=%0d acc=%0d", i,
               vecs[i].s, vecs[i].op, vecs[i].hops, lat, nwb, nfill, nacc);
      check("vec_ended", ended, 1);
      check("vec_latency", lat, vecs[i].lat);
      check("vec_wb_beats", nwb, vecs[i].nwb);
      check("vec_fill_beats", nfill, vecs[i].nfill);
      check("vec_accesses", nacc, vecs[i].nacc);
      compare_events("vec");
    end

    // Timeout: RAM never answers during FILL
    for (int k = 0; k < 4; k++) begin lk_hit[k] = 1'b0; lk_clean[k] = 1'b1; end
    run_cmd(0, 2, 0, 1000, lat, ended, nwb, nfill, nacc);
    $display("timeout: ended=%0d at cycle %0d state=%0d", ended, lat, m_state);
    check("tmo_error_seen", ended, 2);
    check("tmo_error_cycle", lat, 8);
    check("tmo_state_idle", int'(m_state), 0);
    check("tmo_no_fill", nfill, 0);
    @(negedge clk); #1;
    check("tmo_error_one_cycle", int'(m_err), 0);
    check("tmo_no_late_done", int'(m_done), 0);
    for (int k = 0; k < 4; k++) begin lk_hit[k] = 1'b1; lk_clean[k] = 1'b1; end
    run_cmd(0, 2, 0, 0, lat, ended, nwb, nfill, nacc);
    $display("after timeout: read hit lat=%0d", lat);
    check("tmo_next_cmd_done", ended, 1);
    check("tmo_next_cmd_lat", lat, 3);

    // Reset mid-FILL at beat 2
    for (int k = 0; k < 4; k++) begin lk_hit[k] = 1'b0; lk_clean[k] = 1'b1; end
    sel = 0; lk_idx = 0; found = 0; stall_left = 1;
    @(negedge clk);
    cmd_op = 2'b10; cmd_hops = 2'b00; cmd_valid = 1'b1; ram_ready = 1'b0;
    is_hit = 1'b0; is_clean = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      ram_ready = 1'b0;
      #1;
      if (m_ren && m_beat == 2'd2) begin
        found = 1;
        break;
      end
      if (m_ren) begin
        if (stall_left > 0) stall_left--;
        else begin
          ram_ready  = 1'b1;
          stall_left = 1;
        end
      end
    end
    check("rstfill_reached_beat2", found, 1);
    #1 rst_n = 1'b0;
    #1;
    $display("reset mid-fill: ren=%0d state=%0d", m_ren, m_state);
    check("rstfill_ren_drop", int'(m_ren), 0);
    check("rstfill_no_error", int'(m_err), 0);
    check("rstfill_no_done", int'(m_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("rstfill_state_idle", int'(m_state), 0);
    check("rstfill_cmdReady", int'(m_cmd_ready), 1);
    check("rstfill_post_done_err", int'(m_done) + int'(m_err), 0);

    // Randomised commands against the reference model
    for (int t = 0; t < 40; t++) begin
      int s, op, hops, stall;
      s = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 3));
      hops = int'($urandom_range(0, 3));
      stall = int'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) begin
        lk_hit[k] = 1'($urandom_range(0, 1));
        lk_clean[k] = 1'($urandom_range(0, 1));
      end
      model(s == 0, op, hops, stall, mlat);
      run_cmd(s, op, hops, stall, lat, ended, nwb, nfill, nacc);
      $display("rand %0d: sel=%0d op=%0d hops=%0d stall=%0d lat=%0d exp_lat=%0d", t, s,
               op, hops, stall, lat, mlat);
      check("rand_ended", ended, 1);
      check("rand_latency", lat, mlat);
      compare_events("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
